// File: rtl/uart_rx_fifo.sv
// UART receiver (start / DATA_BITS / optional parity / stop) feeding a first-word-fall-through
// receive FIFO with sticky error flags. Define UART_RX_PARITY_EN to add the parity stage.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 32,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    input  logic                          clr_err,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err
);
    localparam int DIV      = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W    = $clog2(DIV);
    localparam int IDX_W    = $clog2(DATA_BITS);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int OCC_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic [OCC_W-1:0] DEPTH     = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    logic                 rx_meta_q, rx_sync_q;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push, frame_set, par_set;
    logic                 do_push, do_pop, ovr_set;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     count_q, count_d;
    logic                 frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    // rx is asynchronous to clk; only rx_sync_q is ever sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        par_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (rx_sync_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = FULL_LOAD;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FULL_LOAD;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (cnt_q == '0) begin
                    par_bad_d = rx_sync_q != ((^shift_q) ^ PARITY_ODD);
                    par_set   = par_bad_d;
                    state_d   = S_STOP;
                    cnt_d     = FULL_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_STOP: begin
                // Leave for IDLE on the sample cycle so a following start bit is not missed.
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (!rx_sync_q) begin
                        frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (!par_bad_q) begin
`else
                    end else begin
`endif
                        push = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A push into a full FIFO survives only if a pop frees the head in the same cycle.
    always_comb begin
        do_pop   = rd_en && (count_q != '0);
        do_push  = push && ((count_q != DEPTH) || do_pop);
        ovr_set  = push && !do_push;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + OCC_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - OCC_W'(1);
        end
        frame_err_d = frame_set | (frame_err_q & ~clr_err);
        overrun_d   = ovr_set   | (overrun_q   & ~clr_err);
`ifdef UART_RX_PARITY_EN
        parity_err_d = par_set  | (parity_err_q & ~clr_err);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    logic unused_par;
    assign unused_par = PARITY_ODD | par_set;
    assign parity_err = 1'b0;
`endif

    assign rd_data   = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH);
    assign count     = count_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule
